// File: rtl/vga_pkg.sv
// Shared VESA 800x600@72 raster constants and receiver state type.
// Derived crossing points are what both sides of the display path compare against.
package vga_pkg;

    localparam int H_VISIBLE = 800;
    localparam int H_FP      = 56;
    localparam int H_PULSE   = 120;
    localparam int H_BP      = 64;
    localparam int V_VISIBLE = 600;
    localparam int V_FP      = 37;
    localparam int V_PULSE   = 6;
    localparam int V_BP      = 23;

    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_PULSE;
    localparam int H_TOTAL  = HS_END + H_BP;
    localparam int H_HALF   = H_VISIBLE / 2;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_PULSE;
    localparam int V_TOTAL  = VS_END + V_BP;

    localparam int HW = 11;
    localparam int VW = 10;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } rx_state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster position counter pair.
// A synchronous load re-phases the raster; v advances on every h wrap.
module vga_raster_cnt
    import vga_pkg::*;
#(
    parameter int H_TOT = vga_pkg::H_TOTAL,
    parameter int V_TOT = vga_pkg::V_TOTAL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [HW-1:0] load_h,
    input  logic [VW-1:0] load_v,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (load) begin
            h <= load_h;
            v <= load_v;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: locks to the raster on vsync, verifies sync every sample,
// and reports the two-colour code once per clean frame.
module vga_rx
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_PULSE   = vga_pkg::H_PULSE,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_PULSE   = vga_pkg::V_PULSE,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic [23:0] code,
    output logic        code_valid,
    output logic        locked,
    output logic        sync_err,
    output logic        pix_err
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_PULSE + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_PULSE + V_BP;

    localparam logic [HW-1:0] HS_LO  = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] HS_HI  = HW'(H_VISIBLE + H_FP + H_PULSE);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_MID  = HW'(H_VISIBLE / 2);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] VS_LO  = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] VS_HI  = VW'(V_VISIBLE + V_FP + V_PULSE);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

    logic          hsync_q, hsync_qq, vsync_q, vsync_qq;
    rgb_t          pix_q, left_r, right_r, pix_ref;
    rx_state_t     state, state_nx;
    logic [HW-1:0] rx_h;
    logic [VW-1:0] rx_v;
    logic          exp_hs, exp_vs, mismatch, frame_end, vfall;
    logic          at_left, at_right, visible, bad_now, pix_bad;
    logic          cnt_load, capture, report, frame_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q  <= 1'b1;
            hsync_qq <= 1'b1;
            vsync_q  <= 1'b1;
            vsync_qq <= 1'b1;
            pix_q    <= '0;
        end else begin
            hsync_q  <= hsync;
            hsync_qq <= hsync_q;
            vsync_q  <= vsync;
            vsync_qq <= vsync_q;
            pix_q    <= '{r: red, g: green, b: blue};
        end
    end

    // Sample carrying the vsync edge sits at (VS_LO, 0); the next one is h=1.
    vga_raster_cnt #(
        .H_TOT(H_TOT),
        .V_TOT(V_TOT)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .load_h (HW'(1)),
        .load_v (VS_LO),
        .h      (rx_h),
        .v      (rx_v)
    );

    assign exp_hs    = !((rx_h >= HS_LO) && (rx_h < HS_HI));
    assign exp_vs    = !((rx_v >= VS_LO) && (rx_v < VS_HI));
    assign mismatch  = (state != SEARCH) &&
                       ((hsync_q != exp_hs) || (vsync_q != exp_vs));
    assign frame_end = (rx_v == V_LAST) && (rx_h == H_LAST);
    assign vfall     = !vsync_q && vsync_qq;

    assign at_left  = (rx_v == '0) && (rx_h == '0);
    assign at_right = (rx_v == '0) && (rx_h == H_MID);
    assign visible  = (rx_v < V_VIS) && (rx_h < H_VIS);
    assign pix_ref  = (rx_h < H_MID) ? (at_left ? pix_q : left_r)
                                     : (at_right ? pix_q : right_r);
    assign bad_now  = visible ? (pix_q != pix_ref) : (pix_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SEARCH:  if (vfall) state_nx = VERIFY;
            VERIFY:  if (mismatch)       state_nx = SEARCH;
                     else if (frame_end) state_nx = LOCKED;
            LOCKED:  if (mismatch) state_nx = SEARCH;
            default: state_nx = SEARCH;
        endcase
    end

    always_comb begin
        cnt_load  = (state == SEARCH) && vfall;
        capture   = (state == LOCKED);
        report    = capture && frame_end && !mismatch;
        frame_bad = pix_bad || bad_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_r     <= '0;
            right_r    <= '0;
            pix_bad    <= 1'b0;
            code       <= '0;
            code_valid <= 1'b0;
            pix_err    <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            sync_err   <= mismatch;
            locked     <= (state_nx == LOCKED);
            code_valid <= report && !frame_bad;
            pix_err    <= report && frame_bad;
            if (report && !frame_bad) code <= {left_r, right_r};
            if (capture) begin
                if (at_left)  left_r  <= pix_q;
                if (at_right) right_r <= pix_q;
                pix_bad <= at_left ? bad_now : frame_bad;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx on a shrunken 15x9 raster driven by a
// behavioural transmitter with one-shot sync/colour fault injection.
module tb_vga_rx;

    localparam int HV = 8, HF = 2, HP = 3, HB = 2;
    localparam int VV = 4, VF = 2, VP = 1, VB = 2;
    localparam int HT = HV + HF + HP + HB;
    localparam int VT = VV + VF + VP + VB;
    localparam int F  = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [3:0]  red = '0, green = '0, blue = '0;
    logic [23:0] code;
    logic        code_valid, locked, sync_err, pix_err;

    int total = 0, bad = 0, cyc = 0, gh = 0, gv = 0;
    int f_idx = -1, f_kind = 0;
    int n_cv = 0, n_pe = 0, n_se = 0, last_cv = 0;
    logic [23:0] gen_in = 24'hF000F0, gen_code = '0;

    vga_rx #(
        .H_VISIBLE(HV), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_PULSE(VP), .V_BP(VB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .code       (code),
        .code_valid (code_valid),
        .locked     (locked),
        .sync_err   (sync_err),
        .pix_err    (pix_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [11:0] c;
        if (gh == 0 && gv == 0) gen_code = gen_in;
        hsync = !(gh >= HV + HF && gh < HV + HF + HP);
        vsync = !(gv >= VV + VF && gv < VV + VF + VP);
        c = (gh < HV / 2) ? gen_code[23:12] : gen_code[11:0];
        if (gv < VV && gh < HV) {red, green, blue} = c;
        else                    {red, green, blue} = 12'h0;
        if (cyc == f_idx) begin
            case (f_kind)
                1: hsync = 1'b1;
                2: red = 4'h3;
                3: blue = 4'h1;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        if (code_valid) begin
            n_cv++;
            last_cv = cyc;
        end
        if (pix_err)  n_pe++;
        if (sync_err) n_se++;
        if (gh == HT - 1) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh++;
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", code, 24'h0);
        chk("rst_flags", {20'h0, code_valid, locked, sync_err, pix_err}, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame verifies, second frame is captured and reported.
        run_to(F);
        chk("pre_lock", 24'(locked), 24'h0);
        tick();
        chk("lock_rise", 24'(locked), 24'h1);
        run_to(2 * F);
        chk("no_early_cv", 24'(n_cv), 24'h0);
        tick();
        chk("first_cv", 24'(code_valid), 24'h1);
        chk("first_code", code, 24'hF000F0);
        run_to(3 * F + 1);
        chk("cv_period", 24'(last_cv), 24'(3 * F + 1));
        chk("cv_count2", 24'(n_cv), 24'h2);

        // Code change mid-frame is reported one frame late.
        run_to(3 * F + 50);
        gen_in = 24'h0F00FF;
        run_to(4 * F + 1);
        chk("old_code_cv", 24'(code_valid), 24'h1);
        chk("old_code", code, 24'hF000F0);
        run_to(5 * F + 1);
        chk("new_code_cv", 24'(code_valid), 24'h1);
        chk("new_code", code, 24'h0F00FF);

        // hsync held high inside the pulse at (2,11).
        f_idx = 5 * F + 2 * HT + 11;
        f_kind = 1;
        run_to(5 * F + 42);
        chk("lock_before_se", 24'(locked), 24'h1);
        tick();
        chk("sync_err", 24'(sync_err), 24'h1);
        chk("lock_drop", 24'(locked), 24'h0);
        run_to(6 * F + 1);
        chk("no_cv_lost", 24'(n_cv), 24'h4);
        chk("relock", 24'(locked), 24'h1);
        run_to(7 * F + 1);
        chk("cv_after_relock", 24'(code_valid), 24'h1);
        chk("se_once", 24'(n_se), 24'h1);

        // Red corrupted on a visible right-half pixel at (2,5).
        f_idx = 7 * F + 2 * HT + 5;
        f_kind = 2;
        run_to(8 * F + 1);
        chk("pix_err_vis", 24'(pix_err), 24'h1);
        chk("no_cv_bad", 24'(code_valid), 24'h0);
        chk("lock_held_vis", 24'(locked), 24'h1);
        chk("code_kept", code, 24'h0F00FF);
        run_to(9 * F + 1);
        chk("clean_cv", 24'(code_valid), 24'h1);

        // Blue set in the front porch at (1,9).
        f_idx = 9 * F + HT + 9;
        f_kind = 3;
        run_to(10 * F + 1);
        chk("pix_err_porch", 24'(pix_err), 24'h1);
        chk("lock_held_porch", 24'(locked), 24'h1);
        run_to(11 * F + 1);
        chk("clean_cv2", 24'(code_valid), 24'h1);

        // Reset mid-frame at (2,5) while locked.
        run_to(11 * F + 2 * HT + 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_code", code, 24'h0);
        chk("mid_rst_flags", {20'h0, code_valid, locked, sync_err, pix_err}, 24'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        run_to(12 * F);
        chk("rst_no_lock", 24'(locked), 24'h0);
        tick();
        chk("rst_relock", 24'(locked), 24'h1);
        run_to(13 * F);
        chk("rst_code_held0", code, 24'h0);
        tick();
        chk("rst_cv", 24'(code_valid), 24'h1);
        chk("rst_code", code, 24'h0F00FF);

        run_to(13 * F + 3);
        chk("tot_cv", 24'(n_cv), 24'h8);
        chk("tot_pe", 24'(n_pe), 24'h2);
        chk("tot_se", 24'(n_se), 24'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_rx.md
# vga_rx

Receive-side counterpart of the VESA 800x600@72 Hz timing generator. Samples `hsync`/`vsync`/RGB at the 50 MHz pixel clock and locks onto the 1040x666 raster. Checks every sync sample and every pixel against the expected waveform, then recovers the 24-bit two-colour code (left half / right half) once per frame. Used for loopback self-test and as a bench monitor for the display path.

## Interface
- `H_VISIBLE`, 800, visible pixels per line
- `H_FP`, 56, horizontal front porch
- `H_PULSE`, 120, hsync low width
- `H_BP`, 64, horizontal back porch (line = 1040)
- `V_VISIBLE`, 600, visible lines
- `V_FP`, 37, vertical front porch
- `V_PULSE`, 6, vsync low width
- `V_BP`, 23, vertical back porch (frame = 666)
- `clk` in 1: pixel clock, 50 MHz; one clock domain
- `rst_n` in 1: reset, asynchronous, active-low
- `hsync` in 1: active-low horizontal sync
- `vsync` in 1: active-low vertical sync
- `red`, `green`, `blue` in 4 each: pixel colour
- `code` out 24: `{R,G,B}` of the left half in [23:12], `{R,G,B}` of the right half in [11:0]
- `code_valid` out 1: one-cycle pulse, `code` is updated in that cycle
- `locked` out 1: high in LOCKED state
- `sync_err` out 1: one-cycle pulse on a sync mismatch while in VERIFY or LOCKED
- `pix_err` out 1: one-cycle pulse at frame end if that frame contained a colour error

## Operation
- All inputs are registered once into the sample stage (`*_q`); `hsync_q` and `vsync_q` also feed a one-deep history (`*_qq`). All logic below operates on the sample stage.
- Counters `rx_h` (11 bit, 0..1039) and `rx_v` (10 bit, 0..665) give the raster position of the current sample. They wrap like the transmitter: `rx_h` wraps 1039→0, and `rx_v` increments on each `rx_h` wrap, wrapping 665→0.
- Expected sync values:
  - hsync is low iff 856 ≤ `rx_h` < 976.
  - vsync is low iff 637 ≤ `rx_v` < 643.
- Visible region: `rx_v` < 600 and `rx_h` < 800. Left half: `rx_h` < 400.
- FSM states: SEARCH, VERIFY, LOCKED.
  - SEARCH: the counters are don't-care. When a vsync falling edge is seen (`vsync_q`=0, `vsync_qq`=1), the sample is at (637,0). Load `rx_v`=637, `rx_h`=1 and go to VERIFY.
  - VERIFY and LOCKED: every sample is compared against the expected hsync and vsync. Any difference pulses `sync_err` in the next cycle and returns the FSM to SEARCH. The edge on the mismatching sample itself is not acted on.
  - VERIFY: at sample (665,1039) with no mismatch, go to LOCKED. No code is produced in VERIFY.
- Colour capture in LOCKED only:
  - At (0,0), latch the RGB sample into `left_r`.
  - At (0,400), latch it into `right_r`.
  - Each visible pixel is compared against the latched value for its half. Pixels not yet latched compare against the live latch input.
  - Every non-visible pixel must be 0.
  - Any difference sets a per-frame sticky `pix_bad`. `pix_bad` clears at (0,0).
- Frame end, at sample (665,1039) in LOCKED with no sync mismatch:
  - If `pix_bad`=0: `code` ← {`left_r`,`right_r`} and pulse `code_valid`.
  - Else: pulse `pix_err` and leave `code` unchanged.
- If the sync mismatch and the frame end fall on the same sample, only `sync_err` pulses.
- `code` holds its last value across loss of lock.

## Timing
- Reset values:
  - `code`=0, `code_valid`=0, `locked`=0, `sync_err`=0, `pix_err`=0.
  - FSM state = SEARCH; counters = 0; `pix_bad`=0.
  - `hsync_q`/`hsync_qq`/`vsync_q`/`vsync_qq` = 1, so no false edge is seen out of reset. `*_q` colour registers = 0.
- Latency: a pin value is in the sample stage 1 cycle after it appears on the pins. All outputs are registered, so `code_valid`/`pix_err`/`sync_err` rise 2 cycles after the causing pixel is on the pins.
- `locked` rises the cycle after the VERIFY→LOCKED transition. It falls in the same cycle that `sync_err` pulses.
- Reset mid-frame: outputs return to reset values immediately. Relock needs the next vsync falling edge, plus one verified frame, plus one captured frame.
- A new transmitter code appears on its pins at frame start. It is reported at the end of that frame, i.e. one frame after the transmitter latched it.

## Structure
- Shared package `vga_pkg` holds the timing constants and derived crossing points (856, 976, 1040, 637, 643, 666, 400). The transmitter is moved to this package as well.
- FSM state enum lives in `vga_pkg`.
- One natural sub-module: `vga_raster_cnt`, the h/v counter pair with synchronous load and wrap. It is reusable by the transmitter.

## Test plan
- Reset, drive from the timing generator with code 0xF000F0 → `locked`=1 after the frame-1 end. First `code_valid` with `code`=0xF000F0 at the frame-2 end (2×692640 cycles after reset, +2). Then exactly one pulse every 692640 cycles, with no errors.
- Change the generator input to 0x0F00FF mid-frame → next report is still 0xF000F0. The following report is 0x0F00FF.
- Force `hsync` high for one cycle at h=900 while LOCKED → `sync_err` pulses once, `locked`=0, no `code_valid` that frame. Relock, then `code_valid` two frames later.
- Corrupt `red` to 0x3 for one pixel at (300,500) → `pix_err` at frame end, no `code_valid`, `locked` stays 1, `code` unchanged. The next clean frame reports normally.
- Drive `blue`=1 at (10,820), in the front porch → `pix_err` at frame end, `locked` stays 1.
- Assert `rst_n` low for 3 cycles at (300,500) while LOCKED → all outputs 0 immediately. Lock reacquired at the vsync fall at v=637 plus one frame.
